// File: rtl/reg_bank_if.sv
// Bus-side signal bundle for reg_bank: control, select, load data and flags.
// The tri-state read driver stays a plain port on reg_bank so it can resolve on the shared bus.
interface reg_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             enable_in;
    logic             enable_out;
    logic [2:0]       op;
    logic [SEL_W-1:0] wr_sel;
    logic [SEL_W-1:0] rd_sel;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             carry;

    modport master (
        output enable_in, enable_out, op, wr_sel, rd_sel, data,
        input  zero, carry
    );

    modport slave (
        input  enable_in, enable_out, op, wr_sel, rd_sel, data,
        output zero, carry
    );
endinterface

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register bank with an in-place ALU-lite write port, tri-state read port and
// registered zero/carry flags. Optional write-through on LOAD: define REG_BANK_BYPASS_EN.
module reg_bank #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    reg_bank_if.slave        bus,
    output wire [WIDTH-1:0]  out
);
    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_INC  = 3'd1,
        OP_DEC  = 3'd2,
        OP_SHL  = 3'd3,
        OP_SHR  = 3'd4,
        OP_ROL  = 3'd5,
        OP_CLR  = 3'd6,
        OP_HOLD = 3'd7
    } op_t;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] result;
    logic             c_next;
    logic             wr_ok;
    logic             rd_ok;
    logic             exec;
    logic [WIDTH-1:0] rd_val;
    op_t              op;

    assign op    = op_t'(bus.op);
    assign wr_ok = int'(bus.wr_sel) < DEPTH;
    assign rd_ok = int'(bus.rd_sel) < DEPTH;
    assign exec  = bus.enable_in && (op != OP_HOLD) && wr_ok;

    always_comb begin
        cur    = wr_ok ? regs[bus.wr_sel] : '0;
        result = cur;
        c_next = 1'b0;
        case (op)
            OP_LOAD: result = bus.data;
            OP_INC:  {c_next, result} = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};
            OP_DEC:  {c_next, result} = {1'b0, cur} - {{WIDTH{1'b0}}, 1'b1};
            OP_SHL:  begin result = {cur[WIDTH-2:0], 1'b0};       c_next = cur[WIDTH-1]; end
            OP_SHR:  begin result = {1'b0, cur[WIDTH-1:1]};       c_next = cur[0];       end
            OP_ROL:  begin result = {cur[WIDTH-2:0], cur[WIDTH-1]}; c_next = cur[WIDTH-1]; end
            OP_CLR:  result = '0;
            default: result = cur;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            bus.zero  <= 1'b0;
            bus.carry <= 1'b0;
        end else if (exec) begin
            regs[bus.wr_sel] <= result;
            bus.zero         <= (result == '0);
            bus.carry        <= c_next;
        end
    end

    always_comb begin
        rd_val = rd_ok ? regs[bus.rd_sel] : '0;
`ifdef REG_BANK_BYPASS_EN
        // write-through only for LOAD; other ops still expose the stored value
        if (bus.enable_in && op == OP_LOAD && wr_ok && bus.rd_sel == bus.wr_sel)
            rd_val = bus.data;
`endif
    end

    assign out = bus.enable_out ? rd_val : {WIDTH{1'bz}};
endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank (default DEPTH=4, WIDTH=8).
// Also exercises the REG_BANK_BYPASS_EN build when that macro is defined.
module tb_reg_bank;
    logic       clk = 1'b0;
    logic       reset;
    wire  [7:0] out;
    int         n_checks = 0;
    int         n_pass   = 0;

    reg_bank_if #(.WIDTH(8), .DEPTH(4)) bus ();

    reg_bank #(.WIDTH(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [1:0] sel, input logic [7:0] d);
        bus.enable_in = 1'b1;
        bus.op        = op;
        bus.wr_sel    = sel;
        bus.data      = d;
        @(posedge clk);
        #1;
        bus.enable_in = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, input logic [7:0] exp, input string tag);
        bus.rd_sel     = sel;
        bus.enable_out = 1'b1;
        #1;
        check(tag, {24'd0, out}, {24'd0, exp});
    endtask

    task automatic flags(input logic z, input logic c, input string tag);
        check(tag, {30'd0, bus.zero, bus.carry}, {30'd0, z, c});
    endtask

    initial begin
        reset          = 1'b0;
        bus.enable_in  = 1'b0;
        bus.enable_out = 1'b0;
        bus.op         = 3'd7;
        bus.wr_sel     = 2'd0;
        bus.rd_sel     = 2'd0;
        bus.data       = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: populate, set both flags, then reset with a concurrent write
        do_op(3'd0, 2'd0, 8'h11);
        do_op(3'd0, 2'd1, 8'h22);
        do_op(3'd0, 2'd2, 8'h33);
        do_op(3'd0, 2'd3, 8'hFF);
        do_op(3'd1, 2'd3, 8'h00);
        rd(2'd1, 8'h22, "pre_rst_r1");
        rd(2'd3, 8'h00, "inc_wrap_r3");
        flags(1'b1, 1'b1, "inc_wrap_flags");
        reset = 1'b0;
        do_op(3'd0, 2'd0, 8'h77);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) rd(2'(i), 8'h00, "rst_reg");
        flags(1'b0, 1'b0, "rst_flags");

        // 2: LOAD then read back, others untouched, released bus
        do_op(3'd0, 2'd2, 8'hA5);
        rd(2'd2, 8'hA5, "load_r2");
        rd(2'd0, 8'h00, "load_r0_same");
        rd(2'd1, 8'h00, "load_r1_same");
        rd(2'd3, 8'h00, "load_r3_same");
        bus.rd_sel     = 2'd2;
        bus.enable_out = 1'b0;
        #1;
        check("out_released", {31'd0, (out === 8'hzz) || (out == 8'h00)}, 32'd1);

        // 3: INC wrap and DEC back
        do_op(3'd0, 2'd1, 8'hFF);
        do_op(3'd1, 2'd1, 8'h00);
        rd(2'd1, 8'h00, "inc_ff");
        flags(1'b1, 1'b1, "inc_ff_flags");
        do_op(3'd2, 2'd1, 8'h00);
        rd(2'd1, 8'hFF, "dec_00");
        flags(1'b0, 1'b1, "dec_00_flags");

        // 4: shifts/rotate and HOLD
        do_op(3'd0, 2'd0, 8'h81);
        do_op(3'd3, 2'd0, 8'h00);
        rd(2'd0, 8'h02, "shl_81");
        flags(1'b0, 1'b1, "shl_flags");
        do_op(3'd4, 2'd0, 8'h00);
        rd(2'd0, 8'h01, "shr_02");
        flags(1'b0, 1'b0, "shr_flags");
        do_op(3'd0, 2'd0, 8'h81);
        do_op(3'd4, 2'd0, 8'h00);
        rd(2'd0, 8'h40, "shr_81");
        flags(1'b0, 1'b1, "shr_81_flags");
        do_op(3'd0, 2'd0, 8'h81);
        do_op(3'd5, 2'd0, 8'h00);
        rd(2'd0, 8'h03, "rol_81");
        flags(1'b0, 1'b1, "rol_flags");
        do_op(3'd7, 2'd0, 8'hEE);
        rd(2'd0, 8'h03, "hold_val");
        flags(1'b0, 1'b1, "hold_flags");
        do_op(3'd2, 2'd3, 8'h00);
        rd(2'd3, 8'hFF, "dec_zero_r3");
        flags(1'b0, 1'b1, "dec_zero_flags");

        // 5: disabled CLR, real CLR, reset beating enable
        do_op(3'd0, 2'd3, 8'h5A);
        bus.enable_in = 1'b0;
        bus.op        = 3'd6;
        bus.wr_sel    = 2'd3;
        @(posedge clk);
        #1;
        rd(2'd3, 8'h5A, "dis_clr_r3");
        flags(1'b0, 1'b0, "dis_clr_flags");
        do_op(3'd6, 2'd3, 8'hAA);
        rd(2'd3, 8'h00, "clr_r3");
        flags(1'b1, 1'b0, "clr_flags");
        do_op(3'd0, 2'd3, 8'h5A);
        do_op(3'd1, 2'd2, 8'h00);
        reset = 1'b0;
        do_op(3'd0, 2'd2, 8'h99);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) rd(2'(i), 8'h00, "rst_en_reg");
        flags(1'b0, 1'b0, "rst_en_flags");

        // 6: same-cycle read/write of reg1
        do_op(3'd0, 2'd1, 8'h11);
        bus.rd_sel     = 2'd1;
        bus.enable_out = 1'b1;
        bus.enable_in  = 1'b1;
        bus.op         = 3'd0;
        bus.wr_sel     = 2'd1;
        bus.data       = 8'h3C;
        #1;
`ifdef REG_BANK_BYPASS_EN
        check("rw_pre_edge", {24'd0, out}, 32'h3C);
`else
        check("rw_pre_edge", {24'd0, out}, 32'h11);
`endif
        @(posedge clk);
        #1;
        bus.enable_in = 1'b0;
        rd(2'd1, 8'h3C, "rw_post_edge");
        bus.enable_in = 1'b1;
        bus.op        = 3'd1;
        #1;
        check("rw_inc_no_bypass", {24'd0, out}, 32'h3C);
        @(posedge clk);
        #1;
        bus.enable_in = 1'b0;
        rd(2'd1, 8'h3D, "rw_inc_post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
